// File: rtl/mul_arbiter_pkg.sv
// Shared types for the multiplier arbiter: FSM state encoding and the
// datapath strobe bundle decoded from the state register.
package mul_arbiter_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LDA  = 3'd2,
        ST_LDB  = 3'd3,
        ST_CHK  = 3'd4,
        ST_ACC  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    typedef struct packed {
        logic clr;
        logic ld_a;
        logic ld_b;
        logic add;
        logic dec_b;
    } strobe_t;

    // Moore decode: each state raises only its own datapath strobes.
    function automatic strobe_t decode_strobes(state_t s);
        strobe_t st;
        st = '0;
        case (s)
            ST_CLR:  st.clr  = 1'b1;
            ST_LDA:  st.ld_a = 1'b1;
            ST_LDB:  st.ld_b = 1'b1;
            ST_ACC: begin
                st.add   = 1'b1;
                st.dec_b = 1'b1;
            end
            default: st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mul_arbiter_rr_arbiter.sv
// Combinational round-robin search: the first requester at or after i_ptr,
// scanning circularly, wins.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_idx,
    output logic             o_valid
);

    logic [IW-1:0] w_pos;

    // Circular priority scan starting at the pointer.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pos = IW'((int'(i_ptr) + i) % N_REQ);
            if (!o_valid && i_req[w_pos]) begin
                o_valid        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin scheduler sharing one repeated-addition multiplier datapath
// between N_REQ requesters.
// Optional build macro: MUL_ARBITER_ZERO_BYPASS_EN -- zero operands skip the
// datapath and finish in one cycle.
//
// Handshake: a requester raises req[i] with stable opa/opb slices and holds it
// until ack[i]; operands are captured in the IDLE cycle that grants it, ack[i]
// is a one-cycle pulse, and result is valid from the cycle after that pulse.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int  N_REQ = 4,
    parameter int  WIDTH = 16,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] opa,
    input  logic [N_REQ*WIDTH-1:0] opb,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       result,
    output logic [IW-1:0]          grant_id,
    output logic                   busy,
    output logic [WIDTH-1:0]       dp_din,
    output logic                   dp_clr,
    output logic                   dp_ldA,
    output logic                   dp_ldB,
    output logic                   dp_add,
    output logic                   dp_decB,
    input  logic                   dp_eqz,
    input  logic [WIDTH-1:0]       dp_prod,
    output logic [ST_W-1:0]        dbg_state
);

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_op_a;
    logic [WIDTH-1:0]  r_op_b;
    logic [WIDTH-1:0]  r_result;
    logic [IW-1:0]     r_grant_id;
    logic [IW-1:0]     r_ptr;
    logic [N_REQ-1:0]  r_grant_oh;
`ifdef MUL_ARBITER_ZERO_BYPASS_EN
    logic              r_zero;
`endif

    logic [N_REQ-1:0]  w_arb_grant;
    logic [IW-1:0]     w_arb_idx;
    logic              w_arb_valid;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;
    strobe_t           w_strobe;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // Operand mux: pick the winning requester's opa/opb slices.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_arb_idx == IW'(i)) begin
                w_sel_a = opa[i*WIDTH +: WIDTH];
                w_sel_b = opb[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: grant, load sequence, then add/decrement until B==0.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
`ifdef MUL_ARBITER_ZERO_BYPASS_EN
                    w_next = (w_sel_a == '0 || w_sel_b == '0) ? ST_DONE : ST_CLR;
`else
                    w_next = ST_CLR;
`endif
                end
            end
            ST_CLR:  w_next = ST_LDA;
            ST_LDA:  w_next = ST_LDB;
            ST_LDB:  w_next = ST_CHK;
            ST_CHK:  w_next = dp_eqz ? ST_DONE : ST_ACC;
            ST_ACC:  w_next = ST_CHK;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        w_strobe = decode_strobes(r_state);
        dp_din   = '0;
        if (r_state == ST_LDA) dp_din = r_op_a;
        if (r_state == ST_LDB) dp_din = r_op_b;
        ack  = (r_state == ST_DONE) ? r_grant_oh : '0;
        busy = (r_state != ST_IDLE);
    end

    assign dp_clr    = w_strobe.clr;
    assign dp_ldA    = w_strobe.ld_a;
    assign dp_ldB    = w_strobe.ld_b;
    assign dp_add    = w_strobe.add;
    assign dp_decB   = w_strobe.dec_b;
    assign result    = r_result;
    assign grant_id  = r_grant_id;
    assign dbg_state = r_state;

    // Capture the winner on grant; publish the product and advance the pointer on DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_result   <= '0;
            r_grant_id <= '0;
            r_grant_oh <= '0;
            r_ptr      <= '0;
`ifdef MUL_ARBITER_ZERO_BYPASS_EN
            r_zero     <= 1'b0;
`endif
        end else begin
            if (r_state == ST_IDLE && w_arb_valid) begin
                r_op_a     <= w_sel_a;
                r_op_b     <= w_sel_b;
                r_grant_id <= w_arb_idx;
                r_grant_oh <= w_arb_grant;
`ifdef MUL_ARBITER_ZERO_BYPASS_EN
                r_zero     <= (w_sel_a == '0 || w_sel_b == '0);
`endif
            end
            if (r_state == ST_DONE) begin
`ifdef MUL_ARBITER_ZERO_BYPASS_EN
                r_result <= r_zero ? '0 : dp_prod;
`else
                r_result <= dp_prod;
`endif
                r_ptr <= (r_grant_id == IW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural multiplier datapath.
module tb_mul_arbiter;

    localparam int N      = 4;
    localparam int W      = 8;
    localparam int IW     = 2;
    localparam int BUDGET = 700;
`ifdef MUL_ARBITER_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req   = '0;
    logic [N*W-1:0]   opa   = '0;
    logic [N*W-1:0]   opb   = '0;
    logic [N-1:0]     ack;
    logic [W-1:0]     result;
    logic [IW-1:0]    grant_id;
    logic             busy;
    logic [W-1:0]     dp_din;
    logic             dp_clr, dp_ldA, dp_ldB, dp_add, dp_decB;
    logic             dp_eqz;
    logic [W-1:0]     dp_prod;
    logic [2:0]       dbg_state;

    mul_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .opa(opa), .opb(opb),
        .ack(ack), .result(result), .grant_id(grant_id), .busy(busy),
        .dp_din(dp_din), .dp_clr(dp_clr), .dp_ldA(dp_ldA), .dp_ldB(dp_ldB),
        .dp_add(dp_add), .dp_decB(dp_decB), .dp_eqz(dp_eqz), .dp_prod(dp_prod),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural multiplier datapath ----------------
    logic [W-1:0] m_dpa = '0, m_dpb = '0, m_dpp = '0;
    always @(posedge clk) begin
        if (dp_clr) begin
            m_dpa <= '0; m_dpb <= '0; m_dpp <= '0;
        end else begin
            if (dp_ldA)  m_dpa <= dp_din;
            if (dp_ldB)  m_dpb <= dp_din;
            if (dp_add)  m_dpp <= m_dpp + m_dpa;
            if (dp_decB) m_dpb <= m_dpb - 1'b1;
        end
    end
    assign dp_eqz  = (m_dpb == '0);
    assign dp_prod = m_dpp;

    // ---------------- reference model / scoreboard ----------------
    int           n_assert = 0;
    int           n_fail   = 0;
    int           m_ptr    = 0;
    int           m_a[N];
    int           m_b[N];
    logic [W-1:0] exp_q[$];

    function automatic int rr_pick(input int ptr, input logic [N-1:0] mask);
        for (int i = 0; i < N; i++)
            if (mask[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    function automatic logic [W-1:0] exp_prod(input int a, input int b);
        return W'((a * b) % (1 << W));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_op(input int i, input int a, input int b);
        opa[i*W +: W] = W'(a);
        opb[i*W +: W] = W'(b);
        m_a[i] = a;
        m_b[i] = b;
    endtask

    // Waits for an ack pulse, tallying strobe activity; scrambles the granted
    // requester's operand bus once the grant is taken.
    task automatic wait_ack(input int scr, output int id, output int t, output logic [N-1:0] ackv,
                            output int gid, output int adds, output int strb, output int bad);
        id = -1; t = 0; ackv = '0; gid = -1; adds = 0; strb = 0; bad = 0;
        for (int n = 0; n < BUDGET; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 0) begin
                opa[scr*W +: W] = W'($urandom);
                opb[scr*W +: W] = W'($urandom);
            end
            if (dp_add) adds++;
            if (dp_clr | dp_ldA | dp_ldB | dp_add | dp_decB) strb++;
            if (($countones({dp_clr, dp_ldA, dp_ldB, dp_add}) > 1) || (dp_add != dp_decB) ||
                (!dp_ldA && !dp_ldB && dp_din != '0)) bad++;
            if (ack != '0) begin
                ackv = ack;
                t    = cyc;
                gid  = int'(grant_id);
                for (int k = N - 1; k >= 0; k--) if (ack[k]) id = k;
                return;
            end
        end
    endtask

    // Serves requester e (expected winner), checks the whole operation, then
    // either drops its request or re-arms it with new operands.
    task automatic serve_expect(input int e, input int t0, input bit keep,
                                input int na, input int nb, output int t_ack);
        int id, t, gid, adds, strb, bad;
        logic [N-1:0] ackv;
        bit zb;
        exp_q.push_back(exp_prod(m_a[e], m_b[e]));
        zb = BYP && (m_a[e] == 0 || m_b[e] == 0);
        wait_ack(e, id, t, ackv, gid, adds, strb, bad);
        check("ack_onehot", ackv, 32'(1) << e);
        check("ack_id", id, e);
        check("grant_id", gid, e);
        check("latency", t - t0, zb ? 1 : 5 + 2 * m_b[e]);
        check("add_pulses", adds, zb ? 0 : m_b[e]);
        check("strobe_cycles", strb, zb ? 0 : 3 + m_b[e]);
        check("strobe_rules", bad, 0);
        t_ack = t;
        m_ptr = (e + 1) % N;
        if (keep) set_op(e, na, nb);
        else      req[e] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("result", result, exp_q.pop_front());
        check("idle_gap_busy", busy, 0);
        check("ack_one_cycle", ack, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_dp_din"}, dp_din, 0);
        check({tag, "_strobes"}, {dp_clr, dp_ldA, dp_ldB, dp_add, dp_decB}, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int t0, ta, e, na, nb;
        int order[5];
        bit rearmed[N];
        bit hit;
        order = '{0, 1, 2, 3, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Contention: all four held with 2x2 -> 0,1,2,3,0.
        for (int i = 0; i < N; i++) set_op(i, 2, 2);
        req = '1;
        t0 = cyc;
        for (int k = 0; k < 5; k++) begin
            check("contention_model", rr_pick(m_ptr, req), order[k]);
            serve_expect(order[k], t0, k < 4, 2, 2, ta);
            t0 = ta + 1;
        end
        req = '0;
        @(negedge clk);
        check("contention_quiet", busy, 0);

        // Single request A=7, B=3.
        set_op(0, 7, 3); req[0] = 1'b1; t0 = cyc;
        serve_expect(0, t0, 0, 0, 0, ta);

        // B=0.
        set_op(2, 9, 0); req[2] = 1'b1; t0 = cyc;
        serve_expect(2, t0, 0, 0, 0, ta);

        // A=0, B=50 (bypass build finishes at cycle 1).
        set_op(1, 0, 50); req[1] = 1'b1; t0 = cyc;
        serve_expect(1, t0, 0, 0, 0, ta);

        // Pointer wrap: serve 3, then 0 and 3 together -> 0 first.
        set_op(3, 3, 1); req[3] = 1'b1; t0 = cyc;
        serve_expect(3, t0, 0, 0, 0, ta);
        set_op(0, 4, 2); set_op(3, 6, 1);
        req[0] = 1'b1; req[3] = 1'b1; t0 = cyc;
        serve_expect(0, t0, 0, 0, 0, ta);
        serve_expect(3, ta + 1, 0, 0, 0, ta);

        // Modular wrap at WIDTH=8: 200*2 = 400 -> 144.
        set_op(1, 200, 2); req[1] = 1'b1; t0 = cyc;
        serve_expect(1, t0, 0, 0, 0, ta);

        // Reset during an ACC cycle.
        set_op(2, 5, 10); req[2] = 1'b1;
        hit = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            @(posedge clk);
            @(negedge clk);
            hit = dp_add;
        end
        check("mid_acc_reached", dp_add, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        req = '0;
        repeat (2) begin
            @(negedge clk);
            check("reset_no_ack", ack, 0);
        end
        rst_n = 1'b1;
        m_ptr = 0;
        set_op(2, 5, 4); req[2] = 1'b1; t0 = cyc;
        serve_expect(2, t0, 0, 0, 0, ta);

        // Randomized rounds against the model.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                set_op(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255),
                       $urandom_range(0, 12));
                rearmed[i] = 1'b0;
            end
            req = N'($urandom_range(1, (1 << N) - 1));
            t0 = cyc;
            while (req != '0) begin
                e = rr_pick(m_ptr, req);
                na = $urandom_range(0, 255);
                nb = $urandom_range(0, 12);
                if (!rearmed[e] && $urandom_range(0, 1) == 1) begin
                    rearmed[e] = 1'b1;
                    serve_expect(e, t0, 1, na, nb, ta);
                end else begin
                    serve_expect(e, t0, 0, 0, 0, ta);
                end
                t0 = ta + 1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
